// File: rtl/image_hfilter_pkg.sv
// Shared types and the 1-2-1 tap arithmetic for the horizontal image filter.
package image_hfilter_pkg;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        pixel_t r;
        pixel_t g;
        pixel_t b;
    } rgb_t;

    localparam int unsigned ROUND = 2;

    // (l + 2c + r + ROUND) >> 2 in 10 bits; the maximum of 1022 fits, so no saturation.
    function automatic pixel_t tap121(input pixel_t l, input pixel_t c, input pixel_t r);
        logic [9:0] sum;
        sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'(ROUND);
        return sum[9:2];
    endfunction

endpackage

// File: rtl/hfilter_tap3.sv
// One channel of one pixel: combinational 1-2-1 smoothing with rounding.
module hfilter_tap3 import image_hfilter_pkg::*; (
    input  pixel_t left_i,
    input  pixel_t center_i,
    input  pixel_t right_i,
    output pixel_t y_o
);

    assign y_o = tap121(left_i, center_i, right_i);

endmodule

// File: rtl/image_hfilter.sv
// Streaming horizontal 1-2-1 filter on a two-pixels-per-clock RGB stream.
// Each accepted pair waits in a pending register until its right neighbour
// arrives (next pair) or, for the last pair of a line, flushes by itself.
module image_hfilter import image_hfilter_pkg::*; #(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       EN_FILTER,
    input  logic       VSYNC_IN,
    input  logic       HSYNC_IN,
    input  logic [7:0] DATA_R0_IN,
    input  logic [7:0] DATA_G0_IN,
    input  logic [7:0] DATA_B0_IN,
    input  logic [7:0] DATA_R1_IN,
    input  logic [7:0] DATA_G1_IN,
    input  logic [7:0] DATA_B1_IN,
    output logic       VSYNC,
    output logic       HSYNC,
    output logic [7:0] DATA_R0,
    output logic [7:0] DATA_G0,
    output logic [7:0] DATA_B0,
    output logic [7:0] DATA_R1,
    output logic [7:0] DATA_G1,
    output logic [7:0] DATA_B1,
    output logic       FRAME_DONE
);

    localparam int unsigned PAIRS = WIDTH / 2;
    localparam int unsigned PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int unsigned LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    rgb_t          pend0_q, pend0_d, pend1_q, pend1_d;
    logic          pend_vld_q, pend_vld_d, pend_last_q, pend_last_d, pend_en_q, pend_en_d;
    rgb_t          left_q, left_d;
    logic [PW-1:0] pair_cnt_q, pair_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    rgb_t          out0_q, out0_d, out1_q, out1_d;
    logic          hsync_q, hsync_d, fd_arm_q, fd_arm_d, frame_done_q, frame_done_d;
    logic [1:0]    vsync_q, vsync_d;

    rgb_t   in0, in1, right, filt0, filt1;
    pixel_t f0_r, f0_g, f0_b, f1_r, f1_g, f1_b;
    logic   trig;

    assign in0   = '{r: DATA_R0_IN, g: DATA_G0_IN, b: DATA_B0_IN};
    assign in1   = '{r: DATA_R1_IN, g: DATA_G1_IN, b: DATA_B1_IN};
    // The last pair of a line replicates its own odd pixel as the right neighbour.
    assign right = pend_last_q ? pend1_q : in0;
    assign trig  = pend_vld_q && (HSYNC_IN || pend_last_q);

    hfilter_tap3 u_tap_r0 (.left_i(left_q.r),  .center_i(pend0_q.r), .right_i(pend1_q.r), .y_o(f0_r));
    hfilter_tap3 u_tap_g0 (.left_i(left_q.g),  .center_i(pend0_q.g), .right_i(pend1_q.g), .y_o(f0_g));
    hfilter_tap3 u_tap_b0 (.left_i(left_q.b),  .center_i(pend0_q.b), .right_i(pend1_q.b), .y_o(f0_b));
    hfilter_tap3 u_tap_r1 (.left_i(pend0_q.r), .center_i(pend1_q.r), .right_i(right.r),   .y_o(f1_r));
    hfilter_tap3 u_tap_g1 (.left_i(pend0_q.g), .center_i(pend1_q.g), .right_i(right.g),   .y_o(f1_g));
    hfilter_tap3 u_tap_b1 (.left_i(pend0_q.b), .center_i(pend1_q.b), .right_i(right.b),   .y_o(f1_b));

    assign filt0 = '{r: f0_r, g: f0_g, b: f0_b};
    assign filt1 = '{r: f1_r, g: f1_g, b: f1_b};

    // Next-state: flush the pending pair on trigger, then capture a new pair if offered.
    always_comb begin
        pend0_d      = pend0_q;
        pend1_d      = pend1_q;
        pend_vld_d   = pend_vld_q;
        pend_last_d  = pend_last_q;
        pend_en_d    = pend_en_q;
        left_d       = left_q;
        pair_cnt_d   = pair_cnt_q;
        line_cnt_d   = line_cnt_q;
        out0_d       = out0_q;
        out1_d       = out1_q;
        hsync_d      = trig;
        fd_arm_d     = 1'b0;
        frame_done_d = fd_arm_q;
        vsync_d      = {vsync_q[0], VSYNC_IN};

        if (trig) begin
            pend_vld_d = 1'b0;
            left_d     = pend1_q;
            out0_d     = pend_en_q ? filt0 : pend0_q;
            out1_d     = pend_en_q ? filt1 : pend1_q;
            if (pend_last_q) begin
                if (line_cnt_q == LW'(HEIGHT - 1)) begin
                    line_cnt_d = '0;
                    fd_arm_d   = 1'b1;
                end else begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
            end
        end

        // Capture after the flush so a new line's first pair can coincide with the old line's flush.
        if (HSYNC_IN) begin
            pend0_d    = in0;
            pend1_d    = in1;
            pend_en_d  = EN_FILTER;
            pend_vld_d = 1'b1;
            if (pair_cnt_q == '0) begin
                left_d = in0;
            end
            if (pair_cnt_q == PW'(PAIRS - 1)) begin
                pair_cnt_d  = '0;
                pend_last_d = 1'b1;
            end else begin
                pair_cnt_d  = pair_cnt_q + 1'b1;
                pend_last_d = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend0_q      <= '0;
            pend1_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_en_q    <= 1'b0;
            left_q       <= '0;
            pair_cnt_q   <= '0;
            line_cnt_q   <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
            hsync_q      <= 1'b0;
            fd_arm_q     <= 1'b0;
            frame_done_q <= 1'b0;
            vsync_q      <= '0;
        end else begin
            pend0_q      <= pend0_d;
            pend1_q      <= pend1_d;
            pend_vld_q   <= pend_vld_d;
            pend_last_q  <= pend_last_d;
            pend_en_q    <= pend_en_d;
            left_q       <= left_d;
            pair_cnt_q   <= pair_cnt_d;
            line_cnt_q   <= line_cnt_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            hsync_q      <= hsync_d;
            fd_arm_q     <= fd_arm_d;
            frame_done_q <= frame_done_d;
            vsync_q      <= vsync_d;
        end
    end

    assign VSYNC      = vsync_q[1];
    assign HSYNC      = hsync_q;
    assign DATA_R0    = out0_q.r;
    assign DATA_G0    = out0_q.g;
    assign DATA_B0    = out0_q.b;
    assign DATA_R1    = out1_q.r;
    assign DATA_G1    = out1_q.g;
    assign DATA_B1    = out1_q.b;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_image_hfilter.sv
// Directed bench for image_hfilter with WIDTH=8, HEIGHT=2.
module tb_image_hfilter;

    logic       clk = 1'b0;
    logic       HRESET = 1'b1;
    logic       EN_FILTER = 1'b1;
    logic       VSYNC_IN = 1'b0;
    logic       HSYNC_IN = 1'b0;
    logic [7:0] DATA_R0_IN = '0, DATA_G0_IN = '0, DATA_B0_IN = '0;
    logic [7:0] DATA_R1_IN = '0, DATA_G1_IN = '0, DATA_B1_IN = '0;
    logic       VSYNC, HSYNC, FRAME_DONE;
    logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;

    image_hfilter #(.WIDTH(8), .HEIGHT(2)) dut (
        .HCLK(clk), .HRESET(HRESET), .EN_FILTER(EN_FILTER),
        .VSYNC_IN(VSYNC_IN), .HSYNC_IN(HSYNC_IN),
        .DATA_R0_IN(DATA_R0_IN), .DATA_G0_IN(DATA_G0_IN), .DATA_B0_IN(DATA_B0_IN),
        .DATA_R1_IN(DATA_R1_IN), .DATA_G1_IN(DATA_G1_IN), .DATA_B1_IN(DATA_B1_IN),
        .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            en;
        logic [0:7][7:0] in_r, in_g, in_b;
        logic [0:7][7:0] ex_r, ex_g, ex_b;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] r0, g0, b0, r1, g1, b1;
    } out_t;

    vec_t vt [4];
    out_t oq [$];
    int   fdq [$];
    out_t mon_o;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output pair and FRAME_DONE pulse away from the active edge.
    always @(negedge clk) begin
        if (HSYNC) begin
            mon_o.cyc = cyc;
            mon_o.r0 = DATA_R0; mon_o.g0 = DATA_G0; mon_o.b0 = DATA_B0;
            mon_o.r1 = DATA_R1; mon_o.g1 = DATA_G1; mon_o.b1 = DATA_B1;
            oq.push_back(mon_o);
        end
        if (FRAME_DONE) fdq.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_pair(input int v, input int k, output int dcyc);
        @(negedge clk);
        HSYNC_IN   = 1'b1;
        EN_FILTER  = vt[v].en;
        DATA_R0_IN = vt[v].in_r[2*k];
        DATA_G0_IN = vt[v].in_g[2*k];
        DATA_B0_IN = vt[v].in_b[2*k];
        DATA_R1_IN = vt[v].in_r[2*k+1];
        DATA_G1_IN = vt[v].in_g[2*k+1];
        DATA_B1_IN = vt[v].in_b[2*k+1];
        dcyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            HSYNC_IN = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        HSYNC_IN = 1'b0;
        HRESET = 1'b1;
        repeat (2) @(negedge clk);
        HRESET = 1'b0;
    endtask

    task automatic compare_pair(input int v, input int k, input int qi);
        if (qi >= oq.size()) begin
            check($sformatf("v%0d_pair%0d_present", v, k), oq.size(), qi + 1);
            return;
        end
        check($sformatf("v%0d_p%0d_r", v, 2*k),   oq[qi].r0, vt[v].ex_r[2*k]);
        check($sformatf("v%0d_p%0d_g", v, 2*k),   oq[qi].g0, vt[v].ex_g[2*k]);
        check($sformatf("v%0d_p%0d_b", v, 2*k),   oq[qi].b0, vt[v].ex_b[2*k]);
        check($sformatf("v%0d_p%0d_r", v, 2*k+1), oq[qi].r1, vt[v].ex_r[2*k+1]);
        check($sformatf("v%0d_p%0d_g", v, 2*k+1), oq[qi].g1, vt[v].ex_g[2*k+1]);
        check($sformatf("v%0d_p%0d_b", v, 2*k+1), oq[qi].b1, vt[v].ex_b[2*k+1]);
    endtask

    task automatic check_fd(input bit exp, input int last_cyc);
        check("frame_done_count", fdq.size(), exp ? 1 : 0);
        if (exp && fdq.size() == 1) check("frame_done_cycle", fdq[0], last_cyc + 1);
        fdq.delete();
    endtask

    task automatic run_line(input int v, input bit fd_exp);
        int d0, dk;
        oq.delete();
        fdq.delete();
        d0 = 0;
        for (int k = 0; k < 4; k++) begin
            drive_pair(v, k, dk);
            if (k == 0) d0 = dk;
        end
        idle(5);
        check($sformatf("v%0d_pairs", v), oq.size(), 4);
        if (oq.size() > 0) check($sformatf("v%0d_latency", v), oq[0].cyc - d0, 2);
        if (oq.size() == 4) check($sformatf("v%0d_contiguous", v), oq[3].cyc - oq[0].cyc, 3);
        for (int k = 0; k < 4; k++) compare_pair(v, k, k);
        check_fd(fd_exp, (oq.size() > 0) ? oq[oq.size()-1].cyc : 0);
    endtask

    initial begin
        int d, d2, sz;

        // Constant line: every channel 100 stays 100.
        vt[0].en   = 1'b1;
        vt[0].in_r = {8{8'd100}}; vt[0].in_g = {8{8'd100}}; vt[0].in_b = {8{8'd100}};
        vt[0].ex_r = {8{8'd100}}; vt[0].ex_g = {8{8'd100}}; vt[0].ex_b = {8{8'd100}};
        // Ramp on R, impulse 255 at pixel 3 on G, constant B.
        vt[1].en   = 1'b1;
        vt[1].in_r = {8'd0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd28};
        vt[1].in_g = {8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[1].in_b = {8{8'd50}};
        vt[1].ex_r = {8'd1, 8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24, 8'd27};
        vt[1].ex_g = {8'd0, 8'd0, 8'd64, 8'd128, 8'd64, 8'd0, 8'd0, 8'd0};
        vt[1].ex_b = {8{8'd50}};
        // Same inputs in bypass: output equals input.
        vt[2].en   = 1'b0;
        vt[2].in_r = vt[1].in_r; vt[2].in_g = vt[1].in_g; vt[2].in_b = vt[1].in_b;
        vt[2].ex_r = vt[1].in_r; vt[2].ex_g = vt[1].in_g; vt[2].ex_b = vt[1].in_b;
        // Alternating 0/255 on R, full scale G, zero B.
        vt[3].en   = 1'b1;
        vt[3].in_r = {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
        vt[3].in_g = {8{8'd255}};
        vt[3].in_b = {8{8'd0}};
        vt[3].ex_r = {8'd64, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd191};
        vt[3].ex_g = {8{8'd255}};
        vt[3].ex_b = {8{8'd0}};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_hsync", HSYNC, 0);
        check("rst_data_r0", DATA_R0, 0);
        check("rst_data_b1", DATA_B1, 0);
        check("rst_vsync", VSYNC, 0);
        check("rst_frame_done", FRAME_DONE, 0);
        HRESET = 1'b0;
        idle(2);

        // VSYNC is a two-flop delay.
        @(negedge clk); VSYNC_IN = 1'b1;
        @(negedge clk); VSYNC_IN = 1'b0;
        check("vsync_d1", VSYNC, 0);
        @(negedge clk); check("vsync_d2", VSYNC, 1);
        @(negedge clk); check("vsync_d3", VSYNC, 0);

        // Table: four separated lines; FRAME_DONE after every second line.
        for (int v = 0; v < 4; v++) run_line(v, (v % 2) == 1);

        // Gap of three idle cycles between pairs 1 and 2.
        oq.delete(); fdq.delete();
        drive_pair(1, 0, d);
        drive_pair(1, 1, d);
        idle(3);
        check("gap_stall_count", oq.size(), 1);
        drive_pair(1, 2, d2);
        drive_pair(1, 3, d);
        idle(5);
        check("gap_pairs", oq.size(), 4);
        if (oq.size() > 1) check("gap_pair1_timing", oq[1].cyc - d2, 1);
        for (int k = 0; k < 4; k++) compare_pair(1, k, k);
        check_fd(1'b0, 0);

        // Reset mid-line after pair 2: pending pair discarded.
        do_reset();
        oq.delete(); fdq.delete();
        drive_pair(3, 0, d);
        drive_pair(3, 1, d);
        drive_pair(3, 2, d);
        @(negedge clk);
        HSYNC_IN = 1'b0;
        check("prereset_hsync", HSYNC, 1);
        #2 HRESET = 1'b1;
        #1;
        check("midrst_hsync", HSYNC, 0);
        check("midrst_data_r0", DATA_R0, 0);
        check("midrst_data_g1", DATA_G1, 0);
        compare_pair(3, 0, 0);
        compare_pair(3, 1, 1);
        repeat (2) @(negedge clk);
        HRESET = 1'b0;
        sz = oq.size();
        idle(4);
        check("midrst_no_flush", oq.size(), sz);
        run_line(3, 1'b0);

        // Back-to-back lines forming a full frame, filter then bypass.
        do_reset();
        oq.delete(); fdq.delete();
        for (int k = 0; k < 4; k++) drive_pair(0, k, d);
        for (int k = 0; k < 4; k++) drive_pair(2, k, d);
        idle(5);
        check("b2b_pairs", oq.size(), 8);
        if (oq.size() == 8) check("b2b_contiguous", oq[7].cyc - oq[0].cyc, 7);
        for (int k = 0; k < 4; k++) compare_pair(0, k, k);
        for (int k = 0; k < 4; k++) compare_pair(2, k, k + 4);
        check_fd(1'b1, (oq.size() > 0) ? oq[oq.size()-1].cyc : 0);

        // Back-to-back filtered lines: second line must not see the first's pixels.
        oq.delete(); fdq.delete();
        for (int k = 0; k < 4; k++) drive_pair(3, k, d);
        for (int k = 0; k < 4; k++) drive_pair(1, k, d);
        idle(5);
        check("b2b2_pairs", oq.size(), 8);
        for (int k = 0; k < 4; k++) compare_pair(3, k, k);
        for (int k = 0; k < 4; k++) compare_pair(1, k, k + 4);
        check_fd(1'b1, (oq.size() > 0) ? oq[oq.size()-1].cyc : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_hfilter.md
Name: image_hfilter

Overview:
- Streaming horizontal 3-tap smoothing filter, weights 1-2-1, per RGB channel.
- Sits between image_read and image_write.
- Consumes the two-pixels-per-clock stream (even pixel 0, odd pixel 1) qualified by HSYNC.
- Produces the same format, time-aligned, for the writer.
- Filtering can be bypassed at runtime; bypass keeps the same latency, so the downstream writer timing is unchanged.

Parameters:
- WIDTH, 768: pixels per line; must be even and >= 4; pairs per line = WIDTH/2.
- HEIGHT, 512: lines per frame; used for FRAME_DONE.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- EN_FILTER  in  1  1 = filter, 0 = bypass. Sampled per input pair, travels with the data.
- VSYNC_IN  in  1  frame sync from the reader; delayed 2 cycles to VSYNC.
- HSYNC_IN  in  1  input pair valid.
- DATA_R0_IN, DATA_G0_IN, DATA_B0_IN  in  8 each  even pixel.
- DATA_R1_IN, DATA_G1_IN, DATA_B1_IN  in  8 each  odd pixel.
- VSYNC  out  1  delayed frame sync.
- HSYNC  out  1  output pair valid.
- DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1  out  8 each  filtered pixels.
- FRAME_DONE  out  1  one-cycle pulse after the final pair of line HEIGHT-1 is output.

Behaviour:
- Reset values: every output 0. Pair counter, line counter, pending-pair register, left-neighbour register and pending flag all cleared. Reset is asynchronous, so asserting it mid-line discards the pending pair with no output.
- Filter equation: y[x] = (p[x-1] + 2*p[x] + p[x+1] + 2) >> 2, computed in 10-bit arithmetic. Result is always <= 255, so no saturation is needed.
- Line edges use replication: p[-1] = p[0] and p[WIDTH] = p[WIDTH-1]. Nothing carries across lines.
- Pipeline: each accepted pair k goes into the pending register P. Output pair k needs pixel 2k+2, so it is computed when one of two events occurs:
  - (a) pair k+1 is accepted; or
  - (b) P holds the last pair of the line, which fires automatically on the cycle after capture.
- On the trigger cycle the result is registered, and HSYNC=1 on the next cycle.
- Latency is 2 cycles when input is contiguous. Gaps (HSYNC_IN=0) stall the pending pair; no output occurs during the stall.
- The left-neighbour register holds pixel 2k-1. At line start it holds the replicated pixel 0.
- Pair counter runs 0..WIDTH/2-1. On accepting index WIDTH/2-1 it wraps to 0 and marks P as last-of-line.
- Line counter increments on each end-of-line flush. After the flush of line HEIGHT-1 it wraps to 0, and FRAME_DONE pulses for 1 cycle, coincident with that final output pair's HSYNC cycle +1.
- Simultaneous events: the flush of the previous line's last pair and acceptance of the next line's first pair in the same cycle is legal. The flush outputs; the new pair goes to P; the left neighbour is reloaded for the new line.
- Bypass: output equals the pending pair unmodified, with the same 2-cycle timing and triggers. The EN_FILTER value captured with a pair governs that pair's output.
- VSYNC is a plain 2-flop delay of VSYNC_IN and does not touch the counters.
- HSYNC_IN while P is not last and no new pair arrives: P holds indefinitely.

Decomposition:
- Package image_hfilter_pkg holds:
  - typedef pixel_t (8-bit);
  - typedef rgb_t {r,g,b};
  - constant ROUND = 2;
  - function tap121(l,c,r) returning pixel_t.
- One sub-module, hfilter_tap3, instantiated 6 times (3 channels x 2 pixels): purely combinational 1-2-1 plus rounding, with the output register in the parent.

Test Plan:
- Constant line: WIDTH=8, all channels 100, contiguous -> 4 output pairs, all 100; first HSYNC 2 cycles after first input.
- Ramp: R = 0,4,8,...,28 -> outputs 1,4,8,12,16,20,24,27. Edges: (0+0+4+2)>>2=1 and (24+56+28+2)>>2=27.
- Impulse: R = 255 at pixel 3 only -> pixel2=64, pixel3=128, pixel4=64, all others 0. Also run with EN_FILTER=0: output equals input exactly.
- Gap: HSYNC_IN low 3 cycles between pairs 1 and 2 -> no output during the gap; pair 1 output appears 1 cycle after pair 2 is accepted; values unchanged vs contiguous.
- Back-to-back lines, WIDTH=8, HEIGHT=2: 8 pairs contiguous -> 8 output pairs, no edge mixing across lines, FRAME_DONE single pulse after the 8th output.
- Reset mid-line: HRESET asserted after pair 2 of a line -> all outputs 0 immediately; the next line after release is filtered correctly from pixel 0.
